// File: rtl/sine_lut_360.sv
// sine_lut_360: full-circle sine from a quarter-wave table, combinational.
// Output is signed Q(ROM_WIDTH).(ROM_WIDTH); the exact +/-1.0 peaks are produced without a ROM entry.
module sine_lut_360 #(
  parameter int    ROM_DEPTH = 64,
  parameter int    ROM_WIDTH = 8,
  parameter string ROM_FILE  = "sine_table_64x8.mem",
  localparam int   ADDRW     = $clog2(4*ROM_DEPTH)
) (
  input  logic [ADDRW-1:0]              angle,
  output logic signed [2*ROM_WIDTH-1:0] sine
);
  localparam int  IW = $clog2(ROM_DEPTH);
  localparam int  OW = 2*ROM_WIDTH;
  localparam real PI = 3.14159265358979323846;
  localparam logic [OW-1:0] ONE = OW'(2**ROM_WIDTH);

  function automatic logic [ROM_WIDTH-1:0] quarter_sine(input int i);
    real r;
    int  v;
    r = $sin(PI * $itor(i) / $itor(2*ROM_DEPTH)) * $itor(2**ROM_WIDTH);
    v = $rtoi(r + 0.5);
    if (v > 2**ROM_WIDTH - 1) v = 2**ROM_WIDTH - 1;
    return ROM_WIDTH'(v);
  endfunction

  logic [ROM_WIDTH-1:0] rom [ROM_DEPTH];
  logic [1:0]           quad;
  logic [IW-1:0]        idx;
  logic [IW-1:0]        mirror;
  logic [OW-1:0]        mag;

  // Table contents are derived from the sine itself so they cannot drift from
  // the ROM_FILE image; an empty file name models an unprogrammed ROM.
  for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
    if (ROM_FILE == "") begin : g_blank
      assign rom[gi] = '0;
    end else begin : g_sine
      assign rom[gi] = quarter_sine(gi);
    end
  end

  assign quad   = angle[ADDRW-1 -: 2];
  assign idx    = angle[IW-1:0];
  assign mirror = IW'(0) - idx;

  always_comb begin
    mag = '0;
    if (quad[0]) begin
      mag = (idx == '0) ? ONE : {{ROM_WIDTH{1'b0}}, rom[mirror]};
    end else begin
      mag = {{ROM_WIDTH{1'b0}}, rom[idx]};
    end
    sine = quad[1] ? -mag : mag;
  end

endmodule

// File: rtl/trig_lut_arbiter.sv
// trig_lut_arbiter: round-robin sharing of one sine_lut_360 between NUM_REQ requesters.
// Cosine is folded into sine by a quarter-turn offset; results return two cycles after transfer.
module trig_lut_arbiter #(
  parameter int    NUM_REQ   = 4,
  parameter int    ROM_DEPTH = 64,
  parameter int    ROM_WIDTH = 8,
  parameter string ROM_FILE  = "sine_table_64x8.mem",
  localparam int   ADDRW     = $clog2(4*ROM_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*ADDRW-1:0] req_angle,
  input  logic [NUM_REQ-1:0]       req_cos,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [2*ROM_WIDTH-1:0]   rsp_data
);
  localparam int IDXW = $clog2(NUM_REQ);

  logic [IDXW-1:0]               ptr;
  logic [IDXW-1:0]               ptr_nxt;
  logic [IDXW-1:0]               gnt_idx;
  logic                          gnt_found;
  logic [IDXW:0]                 cand;
  logic [ADDRW-1:0]              gnt_angle;
  logic [ADDRW-1:0]              gnt_addr;
  logic                          s1_v;
  logic [IDXW-1:0]               s1_id;
  logic [ADDRW-1:0]              s1_addr;
  logic signed [2*ROM_WIDTH-1:0] lut_sine;

  // Scan ptr, ptr+1, ... modulo NUM_REQ; first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IDXW+1)'(k);
      if (cand >= (IDXW+1)'(NUM_REQ)) cand = cand - (IDXW+1)'(NUM_REQ);
      if (!gnt_found && req_valid[cand[IDXW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IDXW-1:0];
      end
    end
  end

  assign req_ready = gnt_found ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign ptr_nxt   = (gnt_idx == IDXW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
  assign gnt_angle = req_angle[gnt_idx*ADDRW +: ADDRW];
  assign gnt_addr  = gnt_angle + (req_cos[gnt_idx] ? ADDRW'(ROM_DEPTH) : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      s1_v    <= 1'b0;
      s1_id   <= '0;
      s1_addr <= '0;
    end else begin
      s1_v <= gnt_found;
      if (gnt_found) begin
        ptr     <= ptr_nxt;
        s1_id   <= gnt_idx;
        s1_addr <= gnt_addr;
      end
    end
  end

  sine_lut_360 #(
    .ROM_DEPTH (ROM_DEPTH),
    .ROM_WIDTH (ROM_WIDTH),
    .ROM_FILE  (ROM_FILE)
  ) u_lut (
    .angle (s1_addr),
    .sine  (lut_sine)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= s1_v ? (NUM_REQ'(1) << s1_id) : '0;
      if (s1_v) rsp_data <= lut_sine;
    end
  end

endmodule

// File: tb/tb_trig_lut_arbiter.sv
// Randomized bench for trig_lut_arbiter against a round-robin / real-valued sine reference.
module tb_trig_lut_arbiter;
  localparam int  NREQ = 4;
  localparam int  AW   = 8;
  localparam real PI   = 3.14159265358979323846;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*AW-1:0] req_angle;
  logic [NREQ-1:0]   req_cos;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [15:0]       rsp_data;

  trig_lut_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_angle (req_angle),
    .req_cos   (req_cos),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int id; int data; } rsp_t;
  rsp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int m_ptr    = 0;
  int m_last   = 0;
  bit pend [NREQ];
  int ang  [NREQ];
  bit cs   [NREQ];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // sin(2*pi*a/256) in Q8.8; magnitude saturates at 255 except the exact +/-90 degree peaks.
  function automatic int model_sine(input int a);
    real s;
    int  m;
    s = $sin(2.0 * PI * $itor(a) / 256.0);
    m = $rtoi(256.0 * ((s < 0.0) ? -s : s) + 0.5);
    if (m > 255 && (a % 128) != 64) m = 255;
    return (s < 0.0) ? -m : m;
  endfunction

  function automatic int count_pend();
    int n = 0;
    for (int i = 0; i < NREQ; i++) if (pend[i]) n++;
    return n;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]         = pend[i];
      req_cos[i]           = pend[i] ? cs[i] : 1'($urandom_range(0, 1));
      req_angle[i*AW +: AW] = pend[i] ? AW'(ang[i]) : AW'($urandom_range(0, 255));
    end
  endtask

  task automatic check_outputs();
    int ev;
    rsp_t e;
    ev = 0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e      = exp_q.pop_front();
      ev     = 1 << e.id;
      m_last = e.data & 32'hFFFF;
    end
    check_eq("rsp_valid", 32'(rsp_valid), 32'(ev));
    check_eq("rsp_data", 32'(rsp_data), 32'(m_last));
  endtask

  // One clock: drive at negedge, check grant, advance, check responses at next negedge.
  task automatic step(output int g);
    int c;
    drive();
    #1;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      c = (m_ptr + k) % NREQ;
      if (g < 0 && pend[c]) g = c;
    end
    check_eq("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    if (g >= 0) begin
      exp_q.push_back('{cyc + 2, g, model_sine((ang[g] + (cs[g] ? 64 : 0)) % 256)});
      m_ptr   = (g + 1) % NREQ;
      pend[g] = 1'b0;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drain(input int n);
    int g;
    repeat (n) step(g);
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    int g;
    n = 0;
    while (count_pend() > 0 && n < budget) begin
      step(g);
      n++;
    end
    check_eq("idle_timeout", 32'(count_pend()), 32'd0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    drive();
    rst_n = 1'b0;
    #1;
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
    exp_q.delete();
    m_ptr  = 0;
    m_last = 0;
    repeat (2) @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    rst_n     = 1'b1;
    req_valid = '0;
    req_cos   = '0;
    req_angle = '0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0;
      ang[i]  = 0;
      cs[i]   = 1'b0;
    end
    #2;
    do_reset();

    // single sin(0)
    pend[0] = 1'b1; ang[0] = 0; cs[0] = 1'b0;
    run_until_idle(8);
    drain(3);

    // cos(0) and sin(64) both hit the +1.0 peak
    pend[1] = 1'b1; ang[1] = 0;  cs[1] = 1'b1;
    pend[2] = 1'b1; ang[2] = 64; cs[2] = 1'b0;
    run_until_idle(8);
    drain(3);

    // cos(255) wraps to sine(63)
    pend[3] = 1'b1; ang[3] = 255; cs[3] = 1'b1;
    run_until_idle(8);
    drain(3);

    // reset with one response visible and another lookup in flight
    pend[0] = 1'b1; ang[0] = 32; cs[0] = 1'b0;
    step(g);
    pend[1] = 1'b1; ang[1] = 100; cs[1] = 1'b1;
    step(g);
    do_reset();
    drain(4);

    // all requesters valid from reset: strict rotation 0,1,2,3,...
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i]) begin
          pend[i] = 1'b1;
          ang[i]  = int'($urandom_range(0, 255));
          cs[i]   = 1'($urandom_range(0, 1));
        end
      end
      step(g);
    end
    run_until_idle(8);
    drain(3);

    // sweep the full circle on requester 0, one lookup per cycle
    for (int a = 0; a < 256; a++) begin
      pend[0] = 1'b1; ang[0] = a; cs[0] = 1'b0;
      step(g);
    end
    drain(3);

    // random traffic with hold-until-transfer requesters
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 55) begin
          pend[i] = 1'b1;
          ang[i]  = int'($urandom_range(0, 255));
          cs[i]   = 1'($urandom_range(0, 1));
        end
      end
      step(g);
    end
    run_until_idle(16);
    drain(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
